// File: rtl/reply_arbiter_pkg.sv
// Shared link-frame constants and the TX frame-sequencer state encoding.
// Frame bytes must stay identical to what cmd_decoder expects on RX.
package reply_arbiter_pkg;

   localparam logic [7:0] PREFIX_DEF   = 8'hA5;
   localparam logic [7:0] ADDR_AST_DEF = 8'h01;
   localparam int         TIMEOUT_DEF  = 48000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_AST,
      S_HDR_SRC,
      S_HDR_LEN,
      S_DATA,
      S_CRC,
      S_DONE
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reply_arbiter_rr_arbiter.sv
// Round-robin pick: first requester strictly after 'last', wrapping modulo N_CH.
// Purely combinational, zero latency, no backpressure.
module rr_arbiter
   import reply_arbiter_pkg::*;
#(
   parameter int N_CH = 5,
   parameter int IW   = idx_w(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [N_CH-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      int j;
      j     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         j = (int'(last) + k) % N_CH;
         if (!any && req[j]) begin
            grant[j] = 1'b1;
            idx      = IW'(j);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reply_arbiter.sv
// Round-robin framer sharing one UART TX byte stream; PREFIX is valid the cycle after ch_req.
// tx_data/tx_valid are registered and held while tx_ready is low; payload pops only into a free slot.
module reply_arbiter
   import reply_arbiter_pkg::*;
#(
   parameter int         N_CH        = 5,
   parameter logic [7:0] PREFIX      = PREFIX_DEF,
   parameter logic [7:0] ADDR_AST    = ADDR_AST_DEF,
   parameter int         TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   ch_req,
   input  logic [N_CH*8-1:0] ch_len,
   input  logic [N_CH*8-1:0] ch_data,
   input  logic [N_CH-1:0]   ch_valid,
   output logic [N_CH-1:0]   ch_ready,
   output logic [N_CH-1:0]   ch_grant,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              err
);

   localparam int             IW      = idx_w(N_CH);
   localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [IW-1:0]  RR_INIT = IW'(N_CH - 1);

   state_t          state;
   logic [IW-1:0]   rr_q;
   logic [IW-1:0]   src_q;
   logic [7:0]      len_q;
   logic [7:0]      cnt_q;
   logic [7:0]      crc_q;
   logic [TW-1:0]   to_q;

   logic [N_CH-1:0] pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            slot_free;
   logic            pop;
   logic [7:0]      pay;
   logic [7:0]      pick_len;
   logic [7:0]      cnt_nxt;
   logic [7:0]      crc_nxt;
   logic [TW-1:0]   to_nxt;

   rr_arbiter #(
      .N_CH (N_CH),
      .IW   (IW)
   ) u_rr (
      .req   (ch_req),
      .last  (rr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign slot_free = !tx_valid || tx_ready;
   assign pay       = ch_data[{src_q, 3'b000} +: 8];
   assign pick_len  = ch_len[{pick_idx, 3'b000} +: 8];
   assign pop       = (state == S_DATA) && slot_free && ch_valid[src_q];
   assign ch_ready  = (state == S_DATA && slot_free) ? ch_grant : '0;
   assign busy      = (state != S_IDLE);
   assign cnt_nxt   = cnt_q + 8'd1;
   assign crc_nxt   = crc_q + pay;
   assign to_nxt    = to_q + TW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         ch_grant <= '0;
         err      <= 1'b0;
         crc_q    <= 8'h00;
         cnt_q    <= 8'h00;
         to_q     <= '0;
         rr_q     <= RR_INIT;
         src_q    <= '0;
         len_q    <= 8'h00;
      end else begin
         err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_any) begin
                  ch_grant <= pick_grant;
                  len_q    <= pick_len;
                  src_q    <= pick_idx;
                  rr_q     <= pick_idx;
                  tx_data  <= PREFIX;
                  tx_valid <= 1'b1;
                  state    <= S_HDR_AST;
               end
            end
            S_HDR_AST: begin
               if (slot_free) begin
                  tx_data <= ADDR_AST;
                  state   <= S_HDR_SRC;
               end
            end
            S_HDR_SRC: begin
               if (slot_free) begin
                  tx_data <= 8'(src_q);
                  state   <= S_HDR_LEN;
               end
            end
            S_HDR_LEN: begin
               if (slot_free) begin
                  tx_data <= len_q;
                  crc_q   <= 8'h00;
                  state   <= (len_q != 8'h00) ? S_DATA : S_CRC;
               end
            end
            S_DATA: begin
               if (pop) begin
                  tx_data  <= pay;
                  tx_valid <= 1'b1;
                  crc_q    <= crc_nxt;
                  cnt_q    <= cnt_nxt;
                  to_q     <= '0;
                  if (cnt_nxt == len_q) state <= S_CRC;
               end else if (slot_free) begin
                  // Starved source: ~crc guarantees the receiver rejects the truncated frame.
                  if (to_nxt == TO_LAST) begin
                     tx_data  <= ~crc_q;
                     tx_valid <= 1'b1;
                     err      <= 1'b1;
                     to_q     <= '0;
                     state    <= S_DONE;
                  end else begin
                     tx_valid <= 1'b0;
                     to_q     <= to_nxt;
                  end
               end
            end
            S_CRC: begin
               if (slot_free) begin
                  tx_data  <= crc_q;
                  tx_valid <= 1'b1;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  ch_grant <= '0;
                  cnt_q    <= 8'h00;
                  crc_q    <= 8'h00;
                  to_q     <= '0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reply_arbiter.sv
// Self-checking bench for reply_arbiter: vector table, hand-written corner sequences, random frames.
module tb_reply_arbiter;

   localparam int N  = 5;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   ch_req, ch_valid, ch_ready, ch_grant;
   logic [N*8-1:0] ch_len, ch_data;
   logic [7:0]     tx_data;
   logic           tx_valid, tx_ready, busy, err;

   always #5 clk = ~clk;

   reply_arbiter #(
      .N_CH        (N),
      .PREFIX      (8'hA5),
      .ADDR_AST    (8'h01),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ch_req   (ch_req),
      .ch_len   (ch_len),
      .ch_data  (ch_data),
      .ch_valid (ch_valid),
      .ch_ready (ch_ready),
      .ch_grant (ch_grant),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .err      (err)
   );

   typedef struct {
      int         src;
      int         len;
      int         sup;
      int         mode;
      logic [7:0] base;
      logic [7:0] step;
      int         exp_crc;
      int         exp_err;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] cq [N][$];
   logic [7:0] got[$];
   int         hs_cyc[$];
   int         len_a[N];
   int         cyc;
   int         err_cnt;
   int         rmode;
   int         last_src;
   logic       saw_ready;
   logic       prev_stall;
   logic [7:0] prev_data;
   logic [N-1:0] grant_or, grant_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] m, input int last);
      for (int k = 1; k <= N; k++)
         if (m[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         ch_valid[i]       = (cq[i].size() > 0);
         ch_data[8*i +: 8] = (cq[i].size() > 0) ? cq[i][0] : 8'h00;
      end
      case (rmode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = (cyc % 3 == 0);
         default: tx_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic clear_q();
      for (int i = 0; i < N; i++) cq[i].delete();
   endtask

   task automatic tick();
      @(negedge clk);
      if (prev_stall) begin
         chk("hold_valid", tx_valid, 1);
         chk("hold_data", tx_data, prev_data);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
         got.push_back(tx_data);
         hs_cyc.push_back(cyc);
         grant_last = ch_grant;
      end
      grant_or |= ch_grant;
      if (ch_ready != '0) begin
         saw_ready = 1'b1;
         chk("pop_into_busy_slot", tx_valid && !tx_ready, 0);
      end
      for (int i = 0; i < N; i++)
         if (ch_valid[i] && ch_ready[i]) void'(cq[i].pop_front());
      if (err) err_cnt++;
      @(posedge clk);
      #1;
      cyc++;
      drive();
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      prev_stall = 1'b0;
      ch_req = '0;
      rmode = 0;
      clear_q();
      drive();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant", ch_grant, 0);
      chk("rst_ready", ch_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      last_src = N - 1;
   endtask

   // Runs one frame; the expected frame is built from the queued payload and the framing rules.
   task automatic do_frame(input string nm, input logic [N-1:0] mask, input int mode);
      int         src, n;
      bit         done, tmo;
      logic [7:0] sum;
      logic [7:0] expq[$];
      src = rr_pick(mask, last_src);
      for (int i = 0; i < N; i++) ch_len[8*i +: 8] = 8'(len_a[i]);
      n   = (cq[src].size() < len_a[src]) ? cq[src].size() : len_a[src];
      tmo = (n < len_a[src]);
      sum = 8'h00;
      expq.push_back(8'hA5);
      expq.push_back(8'h01);
      expq.push_back(8'(src));
      expq.push_back(8'(len_a[src]));
      for (int j = 0; j < n; j++) begin
         expq.push_back(cq[src][j]);
         sum += cq[src][j];
      end
      expq.push_back(tmo ? ~sum : sum);
      got.delete();
      hs_cyc.delete();
      err_cnt = 0;
      saw_ready = 1'b0;
      grant_or = '0;
      grant_last = '0;
      rmode = mode;
      ch_req = mask;
      drive();
      done = 1'b0;
      for (int c = 0; c < 4000 && !done; c++) begin
         tick();
         if (ch_grant != '0) begin
            ch_req = '0;
            for (int i = 0; i < N; i++) ch_len[8*i +: 8] = 8'($urandom);
         end
         if (got.size() > 0 && !busy) done = 1'b1;
      end
      chk({nm, "_finished"}, done, 1);
      chk({nm, "_nbytes"}, got.size(), expq.size());
      for (int k = 0; k < expq.size() && k < got.size(); k++)
         chk($sformatf("%s_byte%0d", nm, k), got[k], expq[k]);
      chk({nm, "_err"}, err_cnt, tmo ? 1 : 0);
      chk({nm, "_grant"}, grant_or, 32'(1 << src));
      chk({nm, "_grant_at_crc"}, grant_last, 32'(1 << src));
      chk({nm, "_ready_seen"}, saw_ready, (len_a[src] != 0) ? 1 : 0);
      last_src = src;
      clear_q();
      drive();
   endtask

   vec_t       tbl[7];
   int         used[N];
   int         s;
   logic [7:0] v;
   logic [N-1:0] m;
   bit         fin;

   initial begin
      rst = 1'b1;
      ch_req = '0;
      ch_len = '0;
      ch_data = '0;
      ch_valid = '0;
      tx_ready = 1'b1;
      cyc = 0;
      rmode = 0;
      last_src = N - 1;
      prev_stall = 1'b0;

      tbl[0] = '{2, 3,   3,   0, 8'h10, 8'h10, 'h60, 0};
      tbl[1] = '{2, 3,   3,   1, 8'h10, 8'h10, 'h60, 0};
      tbl[2] = '{1, 0,   0,   0, 8'h00, 8'h00, 'h00, 0};
      tbl[3] = '{3, 4,   2,   0, 8'h05, 8'h02, 'hF3, 1};
      tbl[4] = '{3, 4,   2,   1, 8'h05, 8'h02, 'hF3, 1};
      tbl[5] = '{0, 255, 255, 2, 8'h00, 8'h01, 'h81, 0};
      tbl[6] = '{4, 5,   5,   2, 8'hF0, 8'h11, 'h5A, 0};

      reset_dut();

      for (int t = 0; t < 7; t++) begin
         for (int i = 0; i < N; i++) len_a[i] = 0;
         clear_q();
         len_a[tbl[t].src] = tbl[t].len;
         v = tbl[t].base;
         for (int j = 0; j < tbl[t].sup; j++) begin
            cq[tbl[t].src].push_back(v);
            v += tbl[t].step;
         end
         do_frame($sformatf("vec%0d", t), N'(1 << tbl[t].src), tbl[t].mode);
         chk($sformatf("vec%0d_last", t), (got.size() > 0) ? got[got.size()-1] : 8'hxx,
             tbl[t].exp_crc);
         chk($sformatf("vec%0d_errpulse", t), err_cnt, tbl[t].exp_err);
      end

      // Round robin with 10011 held, len 1 each: sources 0,1,4,0 with one idle cycle between frames.
      reset_dut();
      for (int i = 0; i < N; i++) begin
         ch_len[8*i +: 8] = 8'd1;
         used[i] = 0;
         for (int j = 0; j < 2; j++) cq[i].push_back(8'(8'h40 + 16 * i + j));
      end
      got.delete();
      hs_cyc.delete();
      ch_req = 5'b10011;
      drive();
      fin = 1'b0;
      for (int c = 0; c < 500 && !fin; c++) begin
         tick();
         if (got.size() >= 19) ch_req = '0;
         if (got.size() >= 24 && !busy) fin = 1'b1;
      end
      chk("rr_finished", fin, 1);
      chk("rr_nbytes", got.size(), 24);
      for (int k = 0; k < 4 && got.size() >= 24; k++) begin
         s = rr_pick(5'b10011, last_src);
         chk($sformatf("rr_src%0d", k), got[6*k+2], s);
         chk($sformatf("rr_data%0d", k), got[6*k+4], 8'(8'h40 + 16 * s + used[s]));
         chk($sformatf("rr_crc%0d", k), got[6*k+5], 8'(8'h40 + 16 * s + used[s]));
         if (k > 0) chk($sformatf("rr_gap%0d", k), hs_cyc[6*k] - hs_cyc[6*k-1], 2);
         used[s]++;
         last_src = s;
      end
      clear_q();
      drive();

      // Reset after the LEN byte: outputs drop at once, then channel 0 wins over channel 4.
      for (int i = 0; i < N; i++) ch_len[8*i +: 8] = 8'd3;
      cq[2].push_back(8'h10);
      cq[2].push_back(8'h20);
      cq[2].push_back(8'h30);
      got.delete();
      rmode = 0;
      ch_req = 5'b00100;
      drive();
      for (int c = 0; c < 100 && got.size() < 4; c++) begin
         tick();
         if (ch_grant != '0) ch_req = '0;
      end
      chk("mr_hdr_bytes", got.size(), 4);
      rst = 1'b1;
      #1;
      chk("mr_tx_valid", tx_valid, 0);
      chk("mr_grant", ch_grant, 0);
      chk("mr_busy", busy, 0);
      prev_stall = 1'b0;
      tick();
      tick();
      chk("mr_no_more_bytes", got.size(), 4);
      rst = 1'b0;
      last_src = N - 1;
      clear_q();
      for (int i = 0; i < N; i++) len_a[i] = 0;
      len_a[0] = 2;
      len_a[4] = 2;
      cq[0].push_back(8'h33);
      cq[0].push_back(8'h44);
      cq[4].push_back(8'h55);
      cq[4].push_back(8'h66);
      do_frame("mr_after", 5'b10001, 0);

      // Random request sets, lengths, starvation and backpressure against the frame model.
      for (int it = 0; it < 20; it++) begin
         m = N'($urandom_range(1, 31));
         clear_q();
         for (int i = 0; i < N; i++) begin
            len_a[i] = $urandom_range(0, 6);
            s = (len_a[i] > 0 && $urandom_range(0, 4) == 0) ? len_a[i] - 1 : len_a[i];
            for (int j = 0; j < s; j++) cq[i].push_back(8'($urandom));
         end
         do_frame($sformatf("rand%0d", it), m, $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
